// File: rtl/common.sv
// Shared types and helpers for the memory-stage load/store path.
// Bus request/response structs match the DCache port.
package common;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic logic [7:0] size_mask(msize_t s);
        case (s)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(logic [2:0] off, msize_t s);
        case (s)
            MSIZE1:  return 1'b0;
            MSIZE2:  return off[0];
            MSIZE4:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and DCache-side signals of the memory access unit.
// slave is the unit itself; master is its environment.
interface mem_access_unit_if;
    import common::*;

    logic        req_valid;
    logic        req_is_store;
    logic [63:0] req_addr;
    msize_t      req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        stall;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign;
    logic        bus_err;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;

    modport slave (
        input  req_valid, req_is_store, req_addr, req_size,
        input  req_unsigned, req_wdata, req_rd, dresp,
        output stall, wb_valid, wb_data, wb_rd,
        output misalign, bus_err, dreq
    );

    modport master (
        output req_valid, req_is_store, req_addr, req_size,
        output req_unsigned, req_wdata, req_rd, dresp,
        input  stall, wb_valid, wb_data, wb_rd,
        input  misalign, bus_err, dreq
    );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering: store shift/strobe and load extract/extend.
// Purely combinational; fed from the latched request.
module mem_align
    import common::*;
(
    input  msize_t      size,
    input  logic [2:0]  off,
    input  logic        is_store,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  strobe,
    output logic [63:0] sdata,
    output logic [63:0] ldata
);

    logic [5:0]  sh;
    logic [63:0] raw;

    assign sh    = {off, 3'b000};
    assign sdata = wdata << sh;
    assign raw   = rdata >> sh;

    // Loads never write, so their strobe stays zero.
    always_comb begin
        strobe = 8'h00;
        if (is_store) strobe = size_mask(size) << off;
    end

    // Truncate the lane-aligned word to size, then extend.
    always_comb begin
        ldata = raw;
        case (size)
            MSIZE1: ldata = is_unsigned ? {56'd0, raw[7:0]}
                                        : {{56{raw[7]}}, raw[7:0]};
            MSIZE2: ldata = is_unsigned ? {48'd0, raw[15:0]}
                                        : {{48{raw[15]}}, raw[15:0]};
            MSIZE4: ldata = is_unsigned ? {32'd0, raw[31:0]}
                                        : {{32{raw[31]}}, raw[31:0]};
            default: ldata = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer in front of DCache.
// Holds the bus request until data_ok; optional watchdog.
module mem_access_unit
    import common::*;
#(
    parameter int MAX_WAIT = 0,
    parameter int CNT_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);

    localparam logic [CNT_BITS-1:0] MAXW = CNT_BITS'(MAX_WAIT);

    mau_state_t          state, state_d;
    logic [CNT_BITS-1:0] cnt, cnt_d, cnt_inc;
    logic                mis_q, mis_d, err_q, err_d;
    logic                st_q, uns_q;
    logic [63:0]         addr_q, wdata_q, rdata_q;
    msize_t              size_q;
    logic [4:0]          rd_q;
    logic                aligned_req, accept;
    logic [7:0]          strobe;
    logic [63:0]         sdata, ldata;
    logic                unused;

    assign unused      = bus.dresp.addr_ok;
    assign aligned_req = bus.req_valid
                       & ~misaligned(bus.req_addr[2:0], bus.req_size);
    assign accept      = (state == IDLE) & aligned_req;
    assign cnt_inc     = cnt + CNT_BITS'(1);

    // State, watchdog count and fault pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end

    // Next state, watchdog and fault decisions.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_valid) begin
                    if (aligned_req) state_d = REQ;
                    else             mis_d   = 1'b1;
                end
            end
            REQ: begin
                if (bus.dresp.data_ok) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (MAX_WAIT != 0 && cnt_inc == MAXW) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the accepted op and the returned read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= MSIZE1;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                st_q    <= bus.req_is_store;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
                rd_q    <= bus.req_rd;
            end
            if (state == REQ && bus.dresp.data_ok)
                rdata_q <= bus.dresp.data;
        end
    end

    mem_align u_align (
        .size        (size_q),
        .off         (addr_q[2:0]),
        .is_store    (st_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (rdata_q),
        .strobe      (strobe),
        .sdata       (sdata),
        .ldata       (ldata)
    );

    // Bus request, stall and writeback outputs.
    always_comb begin
        bus.dreq = '0;
        if (state == REQ) begin
            bus.dreq.valid  = 1'b1;
            bus.dreq.addr   = addr_q;
            bus.dreq.size   = size_q;
            bus.dreq.strobe = strobe;
            bus.dreq.data   = sdata;
        end
        bus.stall    = (state != IDLE) | aligned_req;
        bus.wb_valid = (state == DONE);
        bus.wb_data  = '0;
        bus.wb_rd    = '0;
        if (state == DONE && !st_q) begin
            bus.wb_data = ldata;
            bus.wb_rd   = rd_q;
        end
        bus.misalign = mis_q;
        bus.bus_err  = err_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against an arithmetic model.
// A second instance with MAX_WAIT=8 exercises the watchdog.
module tb_mem_access_unit;
    import common::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    mem_access_unit_if ifa();
    mem_access_unit_if ifw();

    mem_access_unit #(.MAX_WAIT(0), .CNT_BITS(16)) dut (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    mem_access_unit #(.MAX_WAIT(8), .CNT_BITS(16)) dut_w (
        .clk(clk), .reset(reset), .bus(ifw)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(msize_t s);
        return 1 << int'(s);
    endfunction

    function automatic logic [63:0] bmask(int n);
        if (n == 8) return '1;
        return (64'd1 << (8 * n)) - 64'd1;
    endfunction

    function automatic logic [7:0] exp_strobe(bit st, int off, msize_t s);
        logic [15:0] m;
        if (!st) return 8'h00;
        m = ((16'd1 << nbytes(s)) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] exp_load(logic [63:0] rdata, int off,
                                             msize_t s, bit uns);
        logic [63:0] v;
        int n;
        n = nbytes(s);
        v = (rdata >> (8 * off)) & bmask(n);
        if (!uns && v[8 * n - 1]) v = v | ~bmask(n);
        return v;
    endfunction

    function automatic bit is_mis(logic [63:0] addr, msize_t s);
        return (addr % 64'(nbytes(s))) != 0;
    endfunction

    task automatic do_op(string tag, bit st, logic [63:0] addr, msize_t s,
                         bit uns, logic [63:0] wd, logic [4:0] rd,
                         int delay, logic [63:0] rdata);
        int off;
        off = int'(addr[2:0]);
        ifa.req_valid    = 1'b1;
        ifa.req_is_store = st;
        ifa.req_addr     = addr;
        ifa.req_size     = s;
        ifa.req_unsigned = uns;
        ifa.req_wdata    = wd;
        ifa.req_rd       = rd;
        ifa.dresp        = '0;
        #1;
        if (is_mis(addr, s)) begin
            chk({tag, " mis stall"}, ifa.stall, 0);
            chk({tag, " mis dvalid"}, ifa.dreq.valid, 0);
            @(posedge clk); #1;
            ifa.req_valid = 1'b0;
            #1;
            chk({tag, " misalign"}, ifa.misalign, 1);
            chk({tag, " mis dvalid2"}, ifa.dreq.valid, 0);
            chk({tag, " mis wbv"}, ifa.wb_valid, 0);
            @(posedge clk); #1;
            chk({tag, " misalign end"}, ifa.misalign, 0);
        end else begin
            chk({tag, " acc stall"}, ifa.stall, 1);
            chk({tag, " acc dvalid"}, ifa.dreq.valid, 0);
            @(posedge clk); #1;
            for (int c = 0; c <= delay; c++) begin
                ifa.dresp.data_ok = (c == delay);
                ifa.dresp.data    = (c == delay) ? rdata
                                                 : {$urandom, $urandom};
                #1;
                chk({tag, " dvalid"}, ifa.dreq.valid, 1);
                chk({tag, " daddr"}, ifa.dreq.addr, addr);
                chk({tag, " dsize"}, 64'(ifa.dreq.size), 64'(s));
                chk({tag, " strobe"}, ifa.dreq.strobe,
                    exp_strobe(st, off, s));
                if (st) chk({tag, " ddata"}, ifa.dreq.data, wd << (8 * off));
                chk({tag, " req stall"}, ifa.stall, 1);
                chk({tag, " req wbv"}, ifa.wb_valid, 0);
                @(posedge clk); #1;
            end
            ifa.dresp = '0;
            #1;
            chk({tag, " wb_valid"}, ifa.wb_valid, 1);
            chk({tag, " wb_data"}, ifa.wb_data,
                st ? 64'd0 : exp_load(rdata, off, s, uns));
            chk({tag, " wb_rd"}, ifa.wb_rd, st ? 5'd0 : rd);
            chk({tag, " done dvalid"}, ifa.dreq.valid, 0);
            chk({tag, " done stall"}, ifa.stall, 1);
            @(posedge clk); #1;
            ifa.req_valid = 1'b0;
            #1;
            chk({tag, " post wbv"}, ifa.wb_valid, 0);
            chk({tag, " post stall"}, ifa.stall, 0);
        end
    endtask

    initial begin
        ifa.req_valid = 1'b0; ifa.req_is_store = 1'b0;
        ifa.req_addr = '0; ifa.req_size = MSIZE1;
        ifa.req_unsigned = 1'b0; ifa.req_wdata = '0;
        ifa.req_rd = '0; ifa.dresp = '0;
        ifw.req_valid = 1'b0; ifw.req_is_store = 1'b0;
        ifw.req_addr = '0; ifw.req_size = MSIZE1;
        ifw.req_unsigned = 1'b0; ifw.req_wdata = '0;
        ifw.req_rd = '0; ifw.dresp = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", ifa.stall, 0);
        chk("rst wb_valid", ifa.wb_valid, 0);
        chk("rst wb_data", ifa.wb_data, 0);
        chk("rst wb_rd", ifa.wb_rd, 0);
        chk("rst misalign", ifa.misalign, 0);
        chk("rst bus_err", ifa.bus_err, 0);
        chk("rst dreq zero", 64'(ifa.dreq == '0), 1);
        reset = 1'b1;
        @(posedge clk); #1;

        do_op("SD", 1, 64'h8000_0010, MSIZE8, 0,
              64'h1122_3344_5566_7788, 5'd7, 0, 64'h0);
        do_op("SB", 1, 64'h8000_0003, MSIZE1, 0, 64'hAB, 5'd3, 1, 64'h0);
        do_op("LB", 0, 64'h8000_0003, MSIZE1, 0, 64'h0, 5'd4, 0,
              64'h0123_4567_AB9A_BCDE);
        do_op("LBU", 0, 64'h8000_0003, MSIZE1, 1, 64'h0, 5'd5, 2,
              64'h0123_4567_AB9A_BCDE);
        do_op("LW", 0, 64'h8000_0004, MSIZE4, 0, 64'h0, 5'd6, 20,
              64'h8765_4321_0000_0000);
        do_op("LH", 0, 64'h8000_0001, MSIZE2, 0, 64'h0, 5'd8, 0, 64'h0);

        for (int i = 0; i < 40; i++) begin
            msize_t      s;
            logic [2:0]  o;
            logic [63:0] a;
            s = msize_t'($urandom_range(0, 3));
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) != 0)
                o = o & ~3'(nbytes(s) - 1);
            a = {$urandom, $urandom};
            a[2:0] = o;
            do_op("RND", 1'($urandom_range(0, 1)), a, s,
                  1'($urandom_range(0, 1)), {$urandom, $urandom},
                  5'($urandom_range(1, 31)), $urandom_range(0, 4),
                  {$urandom, $urandom});
        end

        ifw.req_valid = 1'b1;
        ifw.req_is_store = 1'b0;
        ifw.req_addr = 64'h8000_0040;
        ifw.req_size = MSIZE8;
        ifw.req_rd = 5'd9;
        #1;
        chk("WD acc stall", ifw.stall, 1);
        @(posedge clk); #1;
        ifw.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("WD dvalid", ifw.dreq.valid, 1);
            chk("WD no err", ifw.bus_err, 0);
            chk("WD stall", ifw.stall, 1);
            @(posedge clk); #1;
        end
        #1;
        chk("WD bus_err", ifw.bus_err, 1);
        chk("WD dvalid off", ifw.dreq.valid, 0);
        chk("WD stall off", ifw.stall, 0);
        chk("WD no wbv", ifw.wb_valid, 0);
        @(posedge clk); #1;
        chk("WD err pulse", ifw.bus_err, 0);

        ifa.req_valid = 1'b1;
        ifa.req_is_store = 1'b0;
        ifa.req_addr = 64'h8000_0020;
        ifa.req_size = MSIZE8;
        ifa.req_rd = 5'd10;
        ifa.dresp = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("RST req3 dvalid", ifa.dreq.valid, 1);
        #1;
        reset = 1'b0;
        ifa.req_valid = 1'b0;
        #1;
        chk("RST async dvalid", ifa.dreq.valid, 0);
        chk("RST wbv", ifa.wb_valid, 0);
        @(posedge clk); #1;
        chk("RST wbv2", ifa.wb_valid, 0);
        chk("RST stall", ifa.stall, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("RST after wbv", ifa.wb_valid, 0);
        do_op("LD", 0, 64'h8000_0028, MSIZE8, 0, 64'h0, 5'd11, 1,
              64'hF0E1_D2C3_B4A5_9687);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
